// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: CPU data-port controller running request/ack transactions on RAM or IO bus, with timeout and alignment checks.
// Defining MIO_READ_BUF_EN adds a one-entry RAM read buffer that lets repeated loads skip the bus.
module mio_bus_ctrl #(
   parameter logic [31:0] IO_BASE = 32'hE000_0000,
   parameter int          TIMEOUT = 16,
   parameter int          TO_W    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        io_req,
   output logic        io_we,
   output logic [31:0] io_addr,
   output logic [31:0] io_wdata,
   input  logic [31:0] io_rdata,
   input  logic        io_ack,
   output logic        bus_err
);
   typedef enum logic [1:0] {IDLE, RAM, IO, DONE} stateType;
   stateType state;
   logic [TO_W-1:0] waitCnt;
   logic aligned, toIo, ack, curWe, timedOut, bufHit;
   logic [31:0] rdata, bufData;
   assign aligned   = cpu_addr[1:0] == 2'b00;
   assign toIo      = cpu_addr >= IO_BASE;
   assign ack       = state == RAM ? mem_ack : (state == IO) & io_ack;
   assign rdata     = state == IO ? io_rdata : mem_rdata;
   assign curWe     = state == IO ? io_we : mem_we;
   assign timedOut  = waitCnt == TO_W'(TIMEOUT - 1);
   assign cpu_ready = (state == IDLE & ~cpu_req) | (state == DONE);
`ifdef MIO_READ_BUF_EN
   logic        bufValid;
   logic [31:0] bufTag;
   assign bufHit = bufValid & bufTag == cpu_addr & aligned & ~toIo & ~cpu_we;
   // Any store invalidates, so the buffer can never return data older than a write.
   always_ff @(posedge clk) begin
      if (reset) begin
         bufValid <= 1'b0;
         bufTag   <= 32'h0;
         bufData  <= 32'h0;
      end else if (state == IDLE && cpu_req && cpu_we) begin
         bufValid <= 1'b0;
      end else if (state == RAM && mem_ack && !mem_we) begin
         bufValid <= 1'b1;
         bufTag   <= mem_addr;
         bufData  <= mem_rdata;
      end
   end
`else
   assign bufHit  = 1'b0;
   assign bufData = 32'h0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         waitCnt   <= '0;
         cpu_rdata <= 32'h0;
         bus_err   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         io_req    <= 1'b0;
         io_we     <= 1'b0;
         io_addr   <= 32'h0;
         io_wdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: if (cpu_req) begin
               if (!aligned) begin
                  state     <= DONE;
                  cpu_rdata <= 32'h0;
                  bus_err   <= 1'b1;
               end else if (bufHit) begin
                  state     <= DONE;
                  cpu_rdata <= bufData;
               end else if (toIo) begin
                  state    <= IO;
                  waitCnt  <= '0;
                  io_req   <= 1'b1;
                  io_we    <= cpu_we;
                  io_addr  <= cpu_addr;
                  io_wdata <= cpu_wdata;
               end else begin
                  state     <= RAM;
                  waitCnt   <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= cpu_we;
                  mem_addr  <= cpu_addr;
                  mem_wdata <= cpu_wdata;
               end
            end
            RAM, IO: if (ack) begin
               state   <= DONE;
               mem_req <= 1'b0;
               io_req  <= 1'b0;
               if (!curWe) cpu_rdata <= rdata;
            end else if (timedOut) begin
               state     <= DONE;
               mem_req   <= 1'b0;
               io_req    <= 1'b0;
               cpu_rdata <= 32'hDEAD_BEEF;
               bus_err   <= 1'b1;
            end else begin
               waitCnt <= waitCnt + 1'b1;
            end
            DONE: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: randomized scoreboard bench for mio_bus_ctrl with a responding RAM/IO slave model.
module tb_mio_bus_ctrl;
   localparam logic [31:0] IO_BASE = 32'hE000_0000;
   localparam int TIMEOUT = 16;
   logic clk = 1'b0, reset;
   logic cpu_req, cpu_we, cpu_ready, bus_err;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic mem_req, mem_we, mem_ack = 1'b0, io_req, io_we, io_ack = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0, io_addr, io_wdata, io_rdata = 32'h0;

   mio_bus_ctrl dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ack(io_ack),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] rdata; int stall; logic err; } expT;
   expT sb[$];
   int errors = 0, checks = 0;
   logic [31:0] lastRdata = 32'h0, bufTag = 32'h0, bufData = 32'h0;
   logic errModel = 1'b0, bufV = 1'b0;
   logic busOn = 1'b0, tgtIo = 1'b0, expWe = 1'b0, doneFlag = 1'b0;
   logic [31:0] expAddr = 32'h0, expWdata = 32'h0, ackData = 32'h0;
   int ackDelay = 255, cnt = 0, stall = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Slave: acks the selected bus after ackDelay cycles of req; random noise acks elsewhere.
   always @(posedge clk) begin
      logic r, a;
      #1;
      r = tgtIo ? io_req : mem_req;
      a = 1'b0;
      if (r) begin
         a = cnt == ackDelay;
         cnt++;
      end else cnt = 0;
      mem_ack   = (!tgtIo && mem_req) ? a : ($urandom_range(3) == 0);
      io_ack    = (tgtIo && io_req) ? a : ($urandom_range(3) == 0);
      mem_rdata = mem_ack ? ackData : $urandom();
      io_rdata  = io_ack ? ackData : $urandom();
   end

   // Bus-side checks: a request only appears on the expected bus with stable fields.
   always @(negedge clk) if (!reset) begin
      if (mem_req) begin
         chk("mem_req_sel", 32'(busOn && !tgtIo), 32'd1);
         chk("mem_we", 32'(mem_we), 32'(expWe));
         chk("mem_addr", mem_addr, expAddr);
         chk("mem_wdata", mem_wdata, expWdata);
      end
      if (io_req) begin
         chk("io_req_sel", 32'(busOn && tgtIo), 32'd1);
         chk("io_we", 32'(io_we), 32'(expWe));
         chk("io_addr", io_addr, expAddr);
         chk("io_wdata", io_wdata, expWdata);
      end
   end

   // CPU-side monitor: counts stall cycles and checks the result when cpu_ready rises.
   always @(negedge clk) if (!reset && cpu_req) begin
      if (!cpu_ready) stall++;
      else begin
         if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            expT e;
            e = sb.pop_front();
            chk("cpu_rdata", cpu_rdata, e.rdata);
            chk("stall_cycles", 32'(stall), 32'(e.stall));
            chk("bus_err", 32'(bus_err), 32'(e.err));
         end
         stall = 0;
         doneFlag = 1'b1;
      end
   end

   task automatic txn(logic [31:0] a, logic w, logic [31:0] wd, int d, logic [31:0] ad);
      expT e;
      logic al, io, hit;
      al = a[1:0] == 2'b00;
      io = a >= IO_BASE;
      hit = 1'b0;
`ifdef MIO_READ_BUF_EN
      hit = al && !io && !w && bufV && bufTag == a;
`endif
      if (!al) begin
         e.rdata = 32'h0; e.stall = 1; errModel = 1'b1;
      end else if (hit) begin
         e.rdata = bufData; e.stall = 1;
      end else if (d < TIMEOUT) begin
         e.stall = d + 2;
         e.rdata = w ? lastRdata : ad;
         if (!io && !w) begin bufV = 1'b1; bufTag = a; bufData = ad; end
      end else begin
         e.rdata = 32'hDEAD_BEEF; e.stall = TIMEOUT + 1; errModel = 1'b1;
      end
      if (w) bufV = 1'b0;
      lastRdata = e.rdata;
      e.err = errModel;
      sb.push_back(e);
      busOn = al && !hit; tgtIo = io; ackDelay = d; ackData = ad;
      expWe = w; expAddr = a; expWdata = wd;
      stall = 0; doneFlag = 1'b0;
      cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
      for (int n = 0; n < 64 && !doneFlag; n++) @(posedge clk);
      if (!doneFlag) begin
         errors++; checks++;
         $display("FAIL done_wait: no cpu_ready for addr %h within 64 cycles", a);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
      #1;
      cpu_req = 1'b0; cpu_we = 1'($urandom()); cpu_addr = $urandom(); cpu_wdata = $urandom();
   endtask

   task automatic abortTxn();
      busOn = 1'b1; tgtIo = 1'b0; ackDelay = 255;
      expWe = 1'b0; expAddr = 32'h100; expWdata = 32'h0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1; reset = 1'b1; cpu_req = 1'b0;
      @(posedge clk);
      #1; reset = 1'b0;
      errModel = 1'b0; lastRdata = 32'h0; bufV = 1'b0;
      @(negedge clk);
      chk("abort_mem_req", 32'(mem_req), 32'd0);
      chk("abort_bus_err", 32'(bus_err), 32'd0);
      chk("abort_rdata", cpu_rdata, 32'h0);
      chk("abort_ready", 32'(cpu_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(cpu_ready), 32'd1);
      chk("rst_reqs", 32'({mem_req, io_req, mem_we, io_we}), 32'd0);
      chk("rst_mem_addr", mem_addr | mem_wdata, 32'h0);
      chk("rst_io_addr", io_addr | io_wdata, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      @(posedge clk); #1; reset = 1'b0;
      txn(32'h0000_0010, 1'b0, 32'h0, 2, 32'h1234_5678);
      txn(32'hE000_0004, 1'b1, 32'hA5A5_A5A5, 3, 32'h0BAD_0BAD);
      txn(32'hE000_0000, 1'b0, 32'h0, 255, 32'h1111_2222);
      txn(32'h0000_0002, 1'b0, 32'h0, 0, 32'h3333_4444);
      abortTxn();
      txn(32'h0000_0010, 1'b0, 32'h0, 0, 32'h5555_6666);
      txn(32'h0000_0020, 1'b0, 32'h0, 1, 32'h2020_2020);
      txn(32'h0000_0020, 1'b0, 32'h0, 1, 32'h7777_8888);
      txn(32'h0000_0040, 1'b1, 32'h4040_4040, 1, 32'h0);
      txn(32'h0000_0020, 1'b0, 32'h0, 1, 32'h9999_AAAA);
      txn(32'hDFFF_FFFC, 1'b0, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
      txn(32'hE000_0008, 1'b1, 32'h1, TIMEOUT, 32'h0);
      abortTxn();
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         int p, d;
         p = $urandom_range(9);
         a = p < 4 ? {26'h0, 4'($urandom()), 2'b00}
           : p < 7 ? IO_BASE + {26'h0, 4'($urandom()), 2'b00}
           : p == 7 ? (($urandom_range(1) == 0) ? 32'hDFFF_FFFC : IO_BASE)
           : p == 8 ? {$urandom()} & 32'hFFFF_FFFC
           : {$urandom()} | 32'h1;
         d = $urandom_range(19) == 0 ? TIMEOUT + $urandom_range(1) : $urandom_range(19) == 0 ? TIMEOUT - 1 : $urandom_range(5);
         txn(a, 1'($urandom()), $urandom(), d, $urandom());
         if ($urandom_range(3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         if ($urandom_range(49) == 0) abortTxn();
      end
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
